matmul_index_sequencer: RTL
===========================

// Module: matmul_index_sequencer
// PURPOSE
//  Drives loop indices (row, k, col) into address_select for a DIMxDIM matrix multiply on one core.
//  Walks all DIM^3 index tuples in order: row outer, col middle, k inner.
//  Holds each tuple until address_select's registered addresses and the memory read settle.
//  Exchanges a valid/ack handshake with the core datapath, and flags accumulator clear and last-term per (row,col).
// PARAMETERS
//  DIM     4   matrix dimension; indices run 0..DIM-1
//  IDX_W   16  width of index outputs, matches address_select in1/in2/in3
//  SETTLE  2   cycles after an index change before idx_valid rises (>=1; covers 1-cycle address_select latency)
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      1-cycle request to begin a full sweep; ignored while busy
//  step_ack   in   1      core has consumed current tuple; sampled only when idx_valid=1
//  idx_row    out  IDX_W  row index -> address_select in1
//  idx_k      out  IDX_W  inner index -> address_select in2 (selects A col / B element)
//  idx_col    out  IDX_W  col index -> address_select in3 (selects B group / D dest)
//  idx_valid  out  1      addresses for current tuple are stable and valid
//  acc_clear  out  1      current tuple is k==0 (core loads instead of accumulates); qualified by idx_valid
//  acc_last   out  1      current tuple is k==DIM-1 (core writes D on ack); qualified by idx_valid
//  busy       out  1      sweep in progress (state != IDLE)
//  done       out  1      1-cycle pulse after final tuple acked
// BEHAVIOUR
//  Reset values: idx_row, idx_k, idx_col = 0; idx_valid, busy, done = 0; settle counter = 0; state = IDLE.
//  acc_clear and acc_last are decoded from idx_k and are not separately registered.
//  FSM states: IDLE, SETTLE, VALID, DONE.
//   IDLE: start=1 -> indices=0, counter=SETTLE-1, go to SETTLE. busy rises the next cycle.
//   SETTLE: counter decrements each cycle; at 0 -> VALID. idx_valid=0 throughout SETTLE.
//   VALID: idx_valid=1; indices frozen until step_ack=1.
//    On ack of a non-final tuple: advance the indices, reload counter=SETTLE-1, go to SETTLE.
//    idx_valid drops in the cycle after the ack.
//    On ack of the final tuple (DIM-1, DIM-1, DIM-1): go to DONE.
//   DONE: done=1 for exactly one cycle, indices return to 0 -> IDLE.
//  Advance order:
//   k increments first.
//   When k==DIM-1: k wraps to 0 and col increments.
//   When col==DIM-1 and k==DIM-1: col wraps to 0 and row increments.
//   No index ever exceeds DIM-1.
//  Throughput: one tuple per SETTLE+1 cycles if ack is returned in the same cycle idx_valid is 1.
//   A full sweep takes DIM^3*(SETTLE+1) cycles plus 1 DONE cycle.
//  step_ack while idx_valid=0: ignored. start while busy: ignored. start and the final ack in the same cycle: start ignored.
//  Index arithmetic: counters are clog2(DIM) bits internally, zero-extended to IDX_W on output.
//  Reset asserted mid-sweep: immediate return to IDLE with reset values; no done pulse; the sweep is not resumed.
//  Index outputs change only on the cycle after an ack (or on start/reset), so address_select sees stable inputs for >=SETTLE edges.
// STRUCTURE
//  Shared package matmul_pkg: DIM default, IDX_W, FSM state encoding, address bases (A=3, B=8, D=24) for bench models.
//  Sub-module idx_counter3: a cascaded 3-digit mod-DIM counter with inc, clear, last_k, last_all outputs.
//   The FSM, settle counter and output decode stay in the top level.
// TESTING
//  1. Reset, then start pulse, ack tied high, SETTLE=2:
//     tuples (0,0,0),(0,1,0),(0,2,0),(0,3,0),(0,0,1),...; idx_valid high 1 cycle in every 3.
//     done pulses at cycle 64*3+1 after start.
//  2. First four tuples: acc_clear=1 only at k=0, acc_last=1 only at k=3.
//     With address_select attached, (row=0,k=3,col=0) gives aa=6, ab=11, ad=24.
//  3. Ack delayed 5 cycles per tuple: indices and idx_valid hold steady; no tuple is skipped or repeated (count 64 acks).
//  4. Ack pulsed during SETTLE, and start pulsed mid-sweep: both ignored; sequence unchanged.
//  5. Reset asserted at tuple (2,1,3), asynchronous to clock: outputs return to 0 before the next edge and no done pulse.
//     A new start restarts from (0,0,0).
//  6. DIM=2, SETTLE=1: 8 tuples; final tuple (1,1,1) ack -> done=1 next cycle, then busy=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul index sequencer: defaults, FSM encoding
// and the address_select base addresses used by bench-side address models.
package matmul_pkg;

  localparam int unsigned DIM_DEF    = 4;
  localparam int unsigned IDX_W_DEF  = 16;
  localparam int unsigned SETTLE_DEF = 2;

  localparam int unsigned A_BASE = 3;
  localparam int unsigned B_BASE = 8;
  localparam int unsigned D_BASE = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idx_counter3.sv
// Cascaded three-digit mod-DIM counter: k is the fastest digit, then col, then row.
module idx_counter3
  import matmul_pkg::*;
#(
  parameter int unsigned DIM = DIM_DEF,
  parameter int unsigned CW  = cnt_width(DIM)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          clear_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] k_o,
  output logic [CW-1:0] col_o,
  output logic          last_k_o,
  output logic          last_all_o
);

  localparam logic [CW-1:0] MAX = CW'(DIM - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] col_q, col_d;
  logic          last_col;

  assign last_k_o   = (k_q == MAX);
  assign last_col   = (col_q == MAX);
  assign last_all_o = last_k_o && last_col && (row_q == MAX);

  always_comb begin
    row_d = row_q;
    k_d   = k_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      k_d   = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (last_k_o) begin
        k_d = '0;
        if (last_col) begin
          col_d = '0;
          row_d = (row_q == MAX) ? '0 : row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end else begin
        k_d = k_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      k_q   <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      k_q   <= k_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign k_o   = k_q;
  assign col_o = col_q;

endmodule

// File: rtl/matmul_index_sequencer.sv
// Walks all (row, col, k) tuples of a DIMxDIM matmul, holding each for SETTLE
// cycles before presenting it to the core with a valid/ack handshake.
module matmul_index_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned DIM    = DIM_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step_ack,
  output logic [IDX_W-1:0] idx_row,
  output logic [IDX_W-1:0] idx_k,
  output logic [IDX_W-1:0] idx_col,
  output logic             idx_valid,
  output logic             acc_clear,
  output logic             acc_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW          = cnt_width(DIM);
  localparam int unsigned   SW          = cnt_width(SETTLE);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          idx_valid_q, busy_q, done_q;
  logic          cnt_inc, cnt_clr;
  logic [CW-1:0] row, k, col;
  logic          last_k, last_all;

  idx_counter3 #(.DIM(DIM), .CW(CW)) u_idx (
    .clock      (clock),
    .reset      (reset),
    .inc_i      (cnt_inc),
    .clear_i    (cnt_clr),
    .row_o      (row),
    .k_o        (k),
    .col_o      (col),
    .last_k_o   (last_k),
    .last_all_o (last_all)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_VALID;
        else             cnt_d   = cnt_q - SW'(1);
      end
      ST_VALID: begin
        if (step_ack) begin
          if (last_all) begin
            cnt_clr = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_valid_q <= (state_d == ST_VALID);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign idx_row   = IDX_W'(row);
  assign idx_k     = IDX_W'(k);
  assign idx_col   = IDX_W'(col);
  assign idx_valid = idx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Accumulator flags follow the held k index directly.
  assign acc_clear = (k == '0);
  assign acc_last  = last_k;

endmodule
